// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops.
// Drives J/K/enable for clear, set, load and N-step up/down counting.
module jk_bank_ctrl #(
  parameter int W  = 4,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    cmd,
  input  logic [W-1:0]  operand,
  input  logic [SW-1:0] steps,
  input  logic [W-1:0]  q_in,
  output logic [W-1:0]  j_out,
  output logic [W-1:0]  k_out,
  output logic          jk_en,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    RUN,
    FIN
  } state_t;

  localparam logic [2:0] C_CLR  = 3'd1;
  localparam logic [2:0] C_SET  = 3'd2;
  localparam logic [2:0] C_LOAD = 3'd3;
  localparam logic [2:0] C_UP   = 3'd4;
  localparam logic [2:0] C_DOWN = 3'd5;

  state_t        state;
  state_t        state_n;
  logic [2:0]    cmd_q;
  logic [2:0]    cmd_n;
  logic [W-1:0]  op_q;
  logic [SW-1:0] cnt_q;
  logic [SW-1:0] cnt_n;
  logic [W-1:0]  up_m;
  logic [W-1:0]  dn_m;
  logic          accept;
  logic          is_apply;
  logic          is_count;
  logic          is_ill;

  assign accept   = (state == IDLE) && start;
  assign cmd_n    = accept ? cmd : cmd_q;
  assign is_apply = (cmd == C_CLR) || (cmd == C_SET)
                 || (cmd == C_LOAD);
  assign is_count = (cmd == C_UP) || (cmd == C_DOWN);
  assign is_ill   = cmd_n[2] & cmd_n[1];

  // Next state and step counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_n = steps;
          unique case (1'b1)
            is_apply: state_n = APPLY;
            is_count: state_n = (steps != '0) ? RUN : FIN;
            default:  state_n = FIN;
          endcase
        end
      end
      APPLY: state_n = FIN;
      RUN: begin
        cnt_n = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) state_n = FIN;
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Toggle masks: a bit flips when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    logic au;
    logic ad;
    au = 1'b1;
    ad = 1'b1;
    for (int i = 0; i < W; i++) begin
      up_m[i] = au;
      dn_m[i] = ad;
      au = au & q_in[i];
      ad = ad & ~q_in[i];
    end
  end

  // Bank drive: J/K and enable from state and captured command
  always_comb begin
    j_out = '0;
    k_out = '0;
    jk_en = 1'b0;
    unique case (state)
      APPLY: begin
        jk_en = 1'b1;
        unique case (cmd_q)
          C_CLR: k_out = '1;
          C_SET: j_out = '1;
          C_LOAD: begin
            j_out = op_q;
            k_out = ~op_q;
          end
          default: ;
        endcase
      end
      RUN: begin
        jk_en = 1'b1;
        j_out = (cmd_q == C_DOWN) ? dn_m : up_m;
        k_out = j_out;
      end
      default: ;
    endcase
  end

  // State, captured command and registered status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cmd_q <= '0;
      op_q  <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt_q <= cnt_n;
      if (accept) begin
        cmd_q <= cmd;
        op_q  <= operand;
      end
      busy <= (state_n != IDLE);
      done <= (state_n == FIN);
      err  <= (state_n == FIN) && is_ill;
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: models the JK bank and checks every cycle
// against a command-level timing model, plus directed literal cases.
module tb_jk_bank_ctrl;
  localparam int W  = 4;
  localparam int SW = 8;

  logic          clk = 0;
  logic          reset = 0;
  logic          start = 0;
  logic [2:0]    cmd = '0;
  logic [W-1:0]  operand = '0;
  logic [SW-1:0] steps = '0;
  logic [W-1:0]  bank = '0;
  logic [W-1:0]  j_out;
  logic [W-1:0]  k_out;
  logic          jk_en;
  logic          busy;
  logic          done;
  logic          err;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jk_bank_ctrl #(.W(W), .SW(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd),
    .operand(operand), .steps(steps), .q_in(bank),
    .j_out(j_out), .k_out(k_out), .jk_en(jk_en),
    .busy(busy), .done(done), .err(err)
  );

  // The JK bank itself
  always @(posedge clk)
    if (jk_en) bank <= (j_out & ~bank) | (~k_out & bank);

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // Command-level model: edge of acceptance, number of bank edges,
  // done edge and final bank value.
  int           cyc = 0;
  bit           act = 0;
  int           m_t = 0;
  int           m_e = 0;
  int           m_d = 0;
  logic [2:0]   m_cmd = '0;
  logic [W-1:0] m_op = '0;
  logic [W-1:0] m_final = '0;
  bit           m_ill = 0;

  always @(posedge clk) begin
    cyc++;
    if (!reset) act = 0;
    else if (start && (!act || cyc >= m_d + 2)) begin
      act = 1;
      m_t = cyc;
      m_cmd = cmd;
      m_op = operand;
      m_ill = (cmd >= 3'd6);
      case (cmd)
        3'd1, 3'd2, 3'd3: m_e = 1;
        3'd4, 3'd5:       m_e = int'(steps);
        default:          m_e = 0;
      endcase
      m_d = m_t + m_e;
      case (cmd)
        3'd1: m_final = '0;
        3'd2: m_final = '1;
        3'd3: m_final = operand;
        3'd4: m_final = bank + W'(steps);
        3'd5: m_final = bank - W'(steps);
        default: m_final = bank;
      endcase
    end
  end

  bit chk_on = 0;

  always @(negedge clk) begin
    logic [W-1:0] ej, ek;
    logic eb, ed, ee, en;
    if (chk_on) begin
      ej = '0; ek = '0; eb = 0; ed = 0; ee = 0; en = 0;
      if (reset && act) begin
        eb = (cyc >= m_t) && (cyc <= m_d);
        ed = (cyc == m_d);
        ee = ed && m_ill;
        en = (cyc >= m_t) && (cyc < m_t + m_e);
        if (en) begin
          case (m_cmd)
            3'd1: ek = '1;
            3'd2: ej = '1;
            3'd3: begin ej = m_op; ek = ~m_op; end
            3'd4: begin ej = bank ^ (bank + W'(1)); ek = ej; end
            3'd5: begin ej = bank ^ (bank - W'(1)); ek = ej; end
            default: ;
          endcase
        end
      end
      chk("cycle", {busy, done, err, jk_en, j_out, k_out},
          {eb, ed, ee, en, ej, ek});
      if (ed) chk("final_bank", bank, m_final);
    end
  end

  logic [W-1:0] hist [0:300];
  logic [W-1:0] hj [0:300];
  logic [W-1:0] hk [0:300];

  task automatic run_cmd(input logic [2:0] c, input logic [W-1:0] op,
                         input logic [SW-1:0] st, output int lat,
                         output int edges, output int errs);
    lat = -1; edges = 0; errs = 0;
    @(posedge clk); #1;
    start = 1; cmd = c; operand = op; steps = st;
    @(posedge clk); #1;
    start = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      hist[k] = bank; hj[k] = j_out; hk[k] = k_out;
      if (jk_en) edges++;
      if (done) begin
        lat = k;
        errs = int'(err);
        break;
      end
    end
    if (lat < 0) begin
      n_run++; n_fail++;
      $display("FAIL timeout: cmd %0d got no done, want done", c);
    end
  endtask

  logic [W-1:0] exp_up [0:4];
  logic [W-1:0] exp_dn [0:2];

  initial begin
    int lat, ed, er, dn;
    exp_up = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};
    exp_dn = '{4'b0000, 4'b1111, 4'b1110};

    @(negedge clk);
    chk_on = 1;
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", {jk_en, busy, done, err, j_out, k_out}, 0);
    @(posedge clk); #1 reset = 1;

    // LOAD 1010
    run_cmd(3'd3, 4'b1010, 0, lat, ed, er);
    chk("load_j", hj[1], 4'b1010);
    chk("load_k", hk[1], 4'b0101);
    chk("load_q", hist[2], 4'b1010);
    chk("load_lat", lat, 2);
    chk("load_edges", ed, 1);
    chk("load_err", er, 0);

    // COUNT_UP 5 from 1101
    run_cmd(3'd3, 4'b1101, 0, lat, ed, er);
    run_cmd(3'd4, 0, 8'd5, lat, ed, er);
    for (int i = 0; i < 5; i++) chk("up_seq", hist[i+2], exp_up[i]);
    chk("up_lat", lat, 6);
    chk("up_edges", ed, 5);

    // COUNT_DOWN 3 from 0001
    run_cmd(3'd3, 4'b0001, 0, lat, ed, er);
    run_cmd(3'd5, 0, 8'd3, lat, ed, er);
    for (int i = 0; i < 3; i++) chk("dn_seq", hist[i+2], exp_dn[i]);
    chk("dn_lat", lat, 4);
    chk("dn_edges", ed, 3);

    // steps=0 and illegal command
    run_cmd(3'd4, 0, 8'd0, lat, ed, er);
    chk("zero_lat", lat, 1);
    chk("zero_edges", ed, 0);
    chk("zero_err", er, 0);
    run_cmd(3'd7, 0, 8'd3, lat, ed, er);
    chk("ill_lat", lat, 1);
    chk("ill_edges", ed, 0);
    chk("ill_err", er, 1);

    // start pulsed during a 10-step count
    run_cmd(3'd3, 4'b0110, 0, lat, ed, er);
    @(posedge clk); #1;
    start = 1; cmd = 3'd4; steps = 8'd10;
    @(posedge clk); #1;
    start = 0;
    ed = 0; dn = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (jk_en) ed++;
      if (done) dn++;
      if (k == 4) begin start = 1; cmd = 3'd2; end
      if (k == 5) start = 0;
    end
    chk("busy_edges", ed, 10);
    chk("busy_dones", dn, 1);
    chk("busy_bank", bank, 4'b0000);

    // reset during the 3rd RUN cycle of a 6-step count
    run_cmd(3'd3, 4'b0011, 0, lat, ed, er);
    @(posedge clk); #1;
    start = 1; cmd = 3'd4; steps = 8'd6;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 0;
    #1 chk("abort_zero", {jk_en, busy, done, err, j_out, k_out}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    chk("abort_bank", bank, 4'b0101);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done | busy) dn++;
    end
    chk("abort_idle", dn, 0);
    run_cmd(3'd0, 0, 0, lat, ed, er);
    chk("post_hold_lat", lat, 1);

    // randomized traffic
    repeat (400) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      cmd = 3'($urandom);
      operand = W'($urandom);
      steps = SW'($urandom_range(0, 9));
    end
    start = 0;
    repeat (20) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Sequencer for a bank of W JK flip-flops built from the team's JK cell. Each JK cell is one bit: next state = (J & ~Q) | (~K & Q), gated by its enable.
- Accepts one command per start/done handshake: clear, set, load, or count up/down for N steps.
- Drives per-bit J/K and a shared bank enable, and reads the bank's Q back.
- Sits between lab-level control logic and the JK register bank, so the bank is never driven directly.

Parameters:
- W, 4, number of JK flip-flops in the controlled bank.
- SW, 8, width of the step-count operand.

Ports:
- clk  input  1  system clock; rising edge; shared with the JK bank.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- cmd  input  3  command code, captured on accepted start.
- operand  input  W  load value for LOAD, captured on accepted start.
- steps  input  SW  number of count edges for COUNT_UP/COUNT_DOWN, captured on accepted start.
- q_in  input  W  current Q outputs of the JK bank.
- j_out  output  W  J inputs to the bank.
- k_out  output  W  K inputs to the bank.
- jk_en  output  1  enable to all bank cells; bank updates on a clk edge where jk_en=1.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse, coincident with done, for an illegal cmd.

Behaviour:
- Reset (reset=0, async): FSM=IDLE; busy, done, err = 0; jk_en=0; j_out=k_out=0; captured registers = 0. Outputs are zero while reset is held. The bank is not driven during or after reset; its own reset is separate.
- FSM states: IDLE, APPLY, RUN, FIN.
- j_out, k_out and jk_en are combinational from state, captured cmd/operand and q_in. They are 0 in IDLE and FIN. busy, done and err are registered.
- IDLE + start=1:
  - Capture cmd, operand, steps.
  - Cmd 1,2,3 → APPLY.
  - Cmd 4,5 → RUN if steps≠0, else FIN.
  - Cmd 0 (HOLD) → FIN.
  - Cmd 6,7 → FIN with err flagged.
- IDLE + start=0: stay in IDLE.
- APPLY (exactly 1 cycle, jk_en=1), then → FIN:
  - CLEAR (1): J=0, K=all ones.
  - SET (2): J=all ones, K=0.
  - LOAD (3): J=operand, K=~operand.
- RUN (jk_en=1, J=K=toggle mask; one bank edge per cycle):
  - UP (4): bit i toggles iff q_in[i-1:0] are all 1; bit0 always toggles.
  - DOWN (5): bit i toggles iff q_in[i-1:0] are all 0; bit0 always toggles.
  - An internal down-counter is loaded with steps and decrements each RUN cycle. Leave RUN → FIN on the cycle the counter equals 1, after that edge.
  - Exactly `steps` bank edges occur.
- FIN: done=1 for one cycle (err=1 too if illegal), then → IDLE.
- busy: high in APPLY, RUN and FIN; low in IDLE.
- Latency, start accepted at edge T:
  - CLEAR/SET/LOAD: bank updates at edge T+1; done high during cycle T+2.
  - COUNT with steps=N: bank edges T+1..T+N; done during cycle T+N+1.
  - HOLD / illegal / steps=0: done during cycle T+1; no bank edge.
- start while busy: ignored, not queued. Captured values are stable for the whole command.
- Wrap-around: UP from all ones → 0; DOWN from 0 → all ones. No flag for either.
- reset asserted mid-operation: the command aborts immediately with no done pulse. The bank keeps whatever value it had at the last completed edge.
- q_in changing externally during RUN: the toggle mask follows q_in cycle-by-cycle; no checking.

Test Plan:
- W=4. Reset, then LOAD with operand=4'b1010 → jk_en high for 1 cycle, j_out=1010, k_out=0101; q_in=1010 next cycle; done at T+2, err=0.
- Bank=4'b1101, COUNT_UP with steps=5 → q_in sequence 1110,1111,0000,0001,0010; exactly 5 jk_en cycles; done at T+6.
- Bank=4'b0001, COUNT_DOWN with steps=3 → q_in sequence 0000,1111,1110; done at T+4.
- COUNT_UP with steps=0; then cmd=3'd7 → each gives done at T+1 with no jk_en; err=0 for the first, err=1 for the second.
- start pulsed again during a 10-step count → ignored; still exactly 10 edges and one done pulse.
- reset pulled low at the 3rd RUN cycle of a 6-step count → outputs 0 asynchronously; no done; bank holds its value after 2 edges; FSM is in IDLE after release.
